// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: launch/status handshake between the UART TX arbiter and
// the shared 8N1 transmitter. Signal directions are named from the arbiter side.
interface uart_tx_arbiter_if;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic       i_TX_Active;
  logic       i_TX_Done;

  modport master (
    output o_TX_DV,
    output o_TX_Byte,
    input  i_TX_Active,
    input  i_TX_Done
  );

  modport slave (
    input  o_TX_DV,
    input  o_TX_Byte,
    output i_TX_Active,
    output i_TX_Done
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 UART transmitter among NUM_REQ byte producers.
// Round-robin grant, one-cycle launch pulse, completion tracking on the rising
// edge of the transmitter's done flag, and a per-frame timeout.
// Optional macro UART_ARB_LOCK_EN adds i_Lock so a locked owner is re-granted
// ahead of the round-robin scan (at most 16 consecutive grants per run).
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2604,
  parameter int GAP_CYCLES     = 1
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst_L,
  input  logic [NUM_REQ-1:0]         i_Req,
  input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         i_Lock,
`endif
  output logic [NUM_REQ-1:0]         o_Req_Ack,
  output logic [NUM_REQ-1:0]         o_Req_Done,
  output logic                       o_Timeout,
  output logic                       o_Busy,
  output logic [$clog2(NUM_REQ)-1:0] o_Owner,
  uart_tx_arbiter_if.master          tx
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

  state_t           r_State;
  state_t           w_NextState;
  logic [IDX_W-1:0] r_Ptr;
  logic [IDX_W-1:0] r_Owner;
  logic [IDX_W-1:0] w_Winner;
  logic [7:0]       r_TxByte;
  logic [7:0]       w_ByteArr [NUM_REQ];
  logic [CNT_W-1:0] r_Cnt;
  logic             r_DoneD;
  logic             w_DoneRise;
  logic             w_Grant;
  logic             w_Found;
  logic             w_TimeoutHit;
  logic             w_GapDone;

`ifdef UART_ARB_LOCK_EN
  logic [4:0]       r_LockRun;
  logic             r_LockBlock;
  logic             w_LockHit;

  // The current owner may jump the queue while it holds its lock, has a new byte,
  // has not used up its run of 16 grants and its last frame did not time out.
  assign w_LockHit = i_Lock[r_Owner] & i_Req[r_Owner] & (r_LockRun < 5'd16) & ~r_LockBlock;
`endif

  // Only a fresh rising edge of done completes a frame; a held-high flag is ignored.
  assign w_DoneRise   = tx.i_TX_Done & ~r_DoneD;
  assign w_TimeoutHit = (int'(r_Cnt) + 1 == TIMEOUT_CYCLES);
  assign w_GapDone    = (int'(r_Cnt) + 1 >= GAP_CYCLES);

  assign o_Owner      = r_Owner;
  assign tx.o_TX_Byte = r_TxByte;
  assign tx.o_TX_DV   = (r_State == LAUNCH);

  // Unpack the flat byte bus and pick the first requester after the pointer.
  always_comb begin
    w_Found  = 1'b0;
    w_Winner = r_Ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_ByteArr[k] = i_Req_Byte[8*k +: 8];
    end
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_Found && i_Req[IDX_W'((int'(r_Ptr) + i) % NUM_REQ)]) begin
        w_Found  = 1'b1;
        w_Winner = IDX_W'((int'(r_Ptr) + i) % NUM_REQ);
      end
    end
`ifdef UART_ARB_LOCK_EN
    if (w_LockHit) begin
      w_Winner = r_Owner;
    end
`endif
  end

  // State register.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State <= IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  // Next state plus the one-cycle ack/done/timeout pulses.
  always_comb begin
    w_NextState = r_State;
    w_Grant     = 1'b0;
    o_Req_Ack   = '0;
    o_Req_Done  = '0;
    o_Timeout   = 1'b0;
    o_Busy      = (r_State != IDLE);
    unique case (r_State)
      IDLE: begin
        // Gating with i_Rst_L keeps the combinational ack quiet during reset.
        if (i_Rst_L && (|i_Req) && !tx.i_TX_Active && !tx.i_TX_Done) begin
          w_Grant             = 1'b1;
          o_Req_Ack[w_Winner] = 1'b1;
          o_Busy              = 1'b1;
          w_NextState         = LAUNCH;
        end
      end
      LAUNCH: begin
        w_NextState = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (w_DoneRise) begin
          o_Req_Done[r_Owner] = 1'b1;
          w_NextState         = GAP;
        end else if (w_TimeoutHit) begin
          o_Timeout   = 1'b1;
          w_NextState = GAP;
        end
      end
      GAP: begin
        if (w_GapDone && !tx.i_TX_Done) begin
          w_NextState = IDLE;
        end
      end
      default: begin
        w_NextState = IDLE;
      end
    endcase
  end

  // Grant bookkeeping, done-edge history and the shared timeout/gap counter.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Ptr       <= IDX_W'(NUM_REQ - 1);
      r_Owner     <= '0;
      r_TxByte    <= '0;
      r_Cnt       <= '0;
      r_DoneD     <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      r_LockRun   <= '0;
      r_LockBlock <= 1'b0;
`endif
    end else begin
      r_DoneD <= tx.i_TX_Done;
      if (w_Grant) begin
        r_TxByte <= w_ByteArr[w_Winner];
        r_Owner  <= w_Winner;
        r_Ptr    <= w_Winner;
      end
      unique case (r_State)
        WAIT_DONE: r_Cnt <= (w_NextState == GAP) ? '0 : r_Cnt + 1'b1;
        GAP:       if (!w_GapDone) r_Cnt <= r_Cnt + 1'b1;
        default:   r_Cnt <= '0;
      endcase
`ifdef UART_ARB_LOCK_EN
      if (w_Grant) begin
        r_LockRun   <= w_LockHit ? r_LockRun + 5'd1 : 5'd1;
        r_LockBlock <= 1'b0;
      end else if (o_Timeout) begin
        r_LockBlock <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmitter among NUM_REQ byte producers.
- Picks requesters round-robin, latches the winner's byte and launches it with a one-cycle DV pulse.
- Tracks frame completion via the transmitter's done flag and reports per-requester completion or timeout.
- Sits between the command/telemetry sources and the UART transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 2604, max cycles from DV pulse to done edge before abort (default 12*217).
- GAP_CYCLES, 1, idle cycles inserted after each frame before the next grant (>=1).

Ports:
- i_Clock  in  1  system clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Req  in  NUM_REQ  per-requester byte-valid; held until acked.
- i_Req_Byte  in  8*NUM_REQ  byte k at [8k+7:8k].
- o_Req_Ack  out  NUM_REQ  one-cycle pulse: byte k taken.
- o_Req_Done  out  NUM_REQ  one-cycle pulse: byte k's frame completed.
- o_Timeout  out  1  one-cycle pulse: current frame aborted by timeout.
- o_Busy  out  1  high from grant until return to IDLE.
- o_Owner  out  $clog2(NUM_REQ)  index of current/last grantee.
- o_TX_DV  out  1  launch pulse to transmitter.
- o_TX_Byte  out  8  byte to transmitter, stable from grant until next grant.
- i_TX_Active  in  1  transmitter busy.
- i_TX_Done  in  1  transmitter done; may stay high 2+ cycles, so only its rising edge counts.

Behaviour:
- Reset (async, immediate): all outputs 0; FSM=IDLE; rr pointer = NUM_REQ-1 so requester 0 wins first; done-edge register 0; counters 0.
- States: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE:
  - Grants only if |i_Req and i_TX_Active=0 and i_TX_Done=0. This covers arbiter reset while the transmitter is mid-frame.
  - Winner = first set i_Req scanning from pointer+1, wrapping modulo NUM_REQ.
  - On the grant cycle: latch byte to o_TX_Byte, o_Owner=winner, pointer=winner, o_Req_Ack[winner]=1, o_Busy=1, next LAUNCH.
- LAUNCH: o_TX_DV=1 for exactly this cycle; clear timeout counter; next WAIT_DONE.
- WAIT_DONE:
  - Counter increments each cycle.
  - Rising edge of i_TX_Done (registered compare): o_Req_Done[owner]=1 for one cycle; next GAP.
  - Counter reaches TIMEOUT_CYCLES with no edge: o_Timeout=1 for one cycle, no o_Req_Done; next GAP.
  - Edge and timeout in the same cycle: the done edge wins.
- GAP: hold for GAP_CYCLES cycles and also until i_TX_Done=0; then o_Busy=0, next IDLE.
- Latency: i_Req seen in IDLE -> ack same cycle -> o_TX_DV next cycle. Back-to-back grant no earlier than GAP_CYCLES+1 cycles after the done edge.
- Handshake:
  - Requester holds i_Req and its byte stable until ack.
  - i_Req still high in the cycle after ack means a new byte.
  - Dropping i_Req before ack withdraws the request with no side effects.
- Requests arriving outside IDLE wait; no queueing beyond one pending byte per requester.
- Only the owner's bit is ever set in o_Req_Ack and o_Req_Done.

Optional Feature:
- Macro UART_ARB_LOCK_EN.
- Defined: adds input i_Lock (NUM_REQ). If i_Lock[owner]=1 and i_Req[owner]=1 on IDLE entry, the owner is re-granted ahead of the round-robin scan, so multi-byte messages are not interleaved. The lock is honoured for at most 16 consecutive grants, then the normal round-robin scan resumes for one grant. A timeout clears the lock privilege for that grant.
- Undefined: no i_Lock port; pure round-robin.

Test Plan:
- Single request: i_Req=0001, byte 0x55, transmitter model CLKS_PER_BIT=4 -> ack[0] at t0, o_TX_DV at t0+1, o_TX_Byte=0x55, o_Req_Done[0] exactly once after the done edge, o_Busy low after GAP.
- Fairness: i_Req=1111 held continuously, bytes 0xA0..0xA3 -> grant order 0,1,2,3,0,1; no requester is acked twice before all others are acked once.
- Done held high: transmitter holds i_TX_Done for 2 cycles -> exactly one o_Req_Done pulse; next o_TX_DV only after i_TX_Done=0 and GAP_CYCLES elapsed.
- Timeout: transmitter never raises done, TIMEOUT_CYCLES=50 -> o_Timeout pulse at 50 cycles after DV, no o_Req_Done, FSM returns to IDLE and grants the next requester.
- Reset mid-frame: assert i_Rst_L low while i_TX_Active=1 -> all outputs 0 immediately; after release, no o_TX_DV until i_TX_Active=0 and i_TX_Done=0; requester 0 wins first.
- With UART_ARB_LOCK_EN: i_Lock[2]=1, i_Req=0110 -> requester 2 granted repeatedly until i_Lock drops or the 16-grant cap; requester 1 is granted on the 17th slot.
